// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the QSPI bus arbiter: FSM state encoding, owner codes
// and the packed transfer-descriptor layout used by requesters and qspi_fsm.
package qspi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BUSY  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_BREAK = 3'd4
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CMD  = 2'b01;
  localparam logic [1:0] OWN_XIP  = 2'b10;

  localparam int DESC_W_DEF = 160;

  // Descriptor layout, LSB first; bits above DESC_USED_W are reserved (zero).
  localparam int LANES_LSB      = 0;
  localparam int LANES_W        = 2;
  localparam int ADDR_BYTES_LSB = 2;
  localparam int ADDR_BYTES_W   = 3;
  localparam int MODE_LSB       = 5;
  localparam int MODE_W         = 2;
  localparam int DUMMY_LSB      = 7;
  localparam int DUMMY_W        = 5;
  localparam int DIR_LSB        = 12;
  localparam int OPCODE_LSB     = 13;
  localparam int OPCODE_W       = 8;
  localparam int ADDR_LSB       = 21;
  localparam int ADDR_W         = 32;
  localparam int LEN_LSB        = 53;
  localparam int LEN_W          = 32;
  localparam int CLK_DIV_LSB    = 85;
  localparam int CLK_DIV_W      = 8;
  localparam int CPOL_LSB       = 93;
  localparam int CPHA_LSB       = 94;
  localparam int CS_AUTO_LSB    = 95;
  localparam int CONT_READ_LSB  = 96;
  localparam int DESC_USED_W    = 97;

  function automatic logic [OPCODE_W-1:0] desc_opcode(input logic [DESC_W_DEF-1:0] d);
    return d[OPCODE_LSB +: OPCODE_W];
  endfunction

endpackage

// File: rtl/qspi_bus_arbiter_prio.sv
// Priority selector between CMD and XIP with a CMD streak counter so that a
// pending XIP request wins after MAX_CMD_STREAK consecutive CMD grants.
module qspi_arb_prio #(
  parameter int MAX_CMD_STREAK = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_eval,
  input  logic i_cmd_req,
  input  logic i_xip_req,
  output logic o_pick_cmd,
  output logic o_pick_xip
);

  localparam int SW = $clog2(MAX_CMD_STREAK + 1);

  logic [SW-1:0] r_streak;

  assign o_pick_cmd = i_cmd_req && (!i_xip_req || (r_streak < SW'(MAX_CMD_STREAK)));
  assign o_pick_xip = !o_pick_cmd && i_xip_req;

  // Only CMD wins that starve a waiting XIP count toward the streak.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_streak <= '0;
    end else if (i_eval) begin
      if (o_pick_cmd && i_xip_req) begin
        r_streak <= r_streak + SW'(1);
      end else if (o_pick_xip) begin
        r_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Shares the qspi_fsm datapath between the CMD engine and xip_engine, with XIP
// continuous-read CS hold. Optional BUSY watchdog: define QSPI_ARB_WATCHDOG_EN.
module qspi_bus_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int DESC_W         = 160,
  parameter int MAX_CMD_STREAK = 4,
  parameter int HOLD_TIMEOUT   = 64
`ifdef QSPI_ARB_WATCHDOG_EN
  , parameter int WDOG_CYCLES  = 4096
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_req_i,
  input  logic [DESC_W-1:0] cmd_desc_i,
  output logic              cmd_gnt_o,
  output logic              cmd_done_o,
  input  logic              xip_req_i,
  input  logic [DESC_W-1:0] xip_desc_i,
  input  logic              xip_hold_i,
  output logic              xip_gnt_o,
  output logic              xip_done_o,
  output logic              xip_break_o,
  output logic              fsm_start_o,
  output logic [DESC_W-1:0] fsm_desc_o,
  input  logic              fsm_done_i,
  output logic              cmd_busy_o,
  output logic [1:0]        owner_o,
`ifdef QSPI_ARB_WATCHDOG_EN
  output logic              wdog_err_o,
`endif
  output logic [2:0]        dbg_state_o
);

  arb_state_t        r_state, w_state_nxt;
  logic [1:0]        r_owner, w_owner_nxt;
  logic              r_term, w_term_nxt;
  logic              w_load, w_load_cmd;
  logic [DESC_W-1:0] r_desc;
  logic              r_cmd_done, r_xip_done, r_cmd_busy;
  logic [31:0]       r_cnt;
  logic              w_eval, w_pick_cmd, w_pick_xip, w_busy_end, w_wdog_to;

  assign w_eval = (r_state == ST_IDLE);

  qspi_arb_prio #(
    .MAX_CMD_STREAK(MAX_CMD_STREAK)
  ) u_prio (
    .clk       (clk),
    .resetn    (resetn),
    .i_eval    (w_eval),
    .i_cmd_req (cmd_req_i),
    .i_xip_req (xip_req_i),
    .o_pick_cmd(w_pick_cmd),
    .o_pick_xip(w_pick_xip)
  );

`ifdef QSPI_ARB_WATCHDOG_EN
  logic r_wdog;
  assign w_wdog_to = (r_state == ST_BUSY) && !fsm_done_i && (r_cnt == 32'(WDOG_CYCLES - 1));
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_wdog <= 1'b0;
    else         r_wdog <= w_wdog_to;
  end
  assign wdog_err_o = r_wdog;
`else
  assign w_wdog_to = 1'b0;
`endif

  assign w_busy_end = (r_state == ST_BUSY) && (fsm_done_i || w_wdog_to);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_term_nxt  = r_term;
    w_load      = 1'b0;
    w_load_cmd  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_cmd) begin
          w_state_nxt = ST_START;
          w_owner_nxt = OWN_CMD;
          w_load      = 1'b1;
          w_load_cmd  = 1'b1;
          w_term_nxt  = 1'b0;
        end else if (w_pick_xip) begin
          w_state_nxt = ST_START;
          w_owner_nxt = OWN_XIP;
          w_load      = 1'b1;
          w_term_nxt  = 1'b0;
        end
      end
      ST_START: w_state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (w_busy_end) begin
          // A terminating read (started from BREAK) never re-enters HOLD.
          if ((r_owner == OWN_XIP) && xip_hold_i && !r_term && !w_wdog_to) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_owner_nxt = OWN_NONE;
          end
        end
      end
      ST_HOLD: begin
        if (xip_req_i) begin
          w_state_nxt = ST_START;
          w_load      = 1'b1;
          w_term_nxt  = 1'b0;
        end else if (cmd_req_i) begin
          w_state_nxt = ST_BREAK;
        end else if (!xip_hold_i) begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_NONE;
        end else if (r_cnt == 32'(HOLD_TIMEOUT - 1)) begin
          w_state_nxt = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (xip_req_i) begin
          w_state_nxt = ST_START;
          w_load      = 1'b1;
          w_term_nxt  = 1'b1;
        end else if (!xip_hold_i) begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_NONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  // r_cnt measures time spent in the current state; any state change restarts it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_NONE;
      r_term     <= 1'b0;
      r_cnt      <= '0;
      r_desc     <= '0;
      r_cmd_done <= 1'b0;
      r_xip_done <= 1'b0;
      r_cmd_busy <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_term     <= w_term_nxt;
      r_cnt      <= (w_state_nxt != r_state) ? 32'd0 : r_cnt + 32'd1;
      if (w_load) begin
        r_desc <= w_load_cmd ? cmd_desc_i : xip_desc_i;
      end
      r_cmd_done <= w_busy_end && (r_owner == OWN_CMD);
      r_xip_done <= w_busy_end && (r_owner == OWN_XIP);
      r_cmd_busy <= cmd_req_i || (w_owner_nxt == OWN_CMD);
    end
  end

  assign cmd_gnt_o   = (r_owner == OWN_CMD);
  assign xip_gnt_o   = (r_owner == OWN_XIP);
  assign owner_o     = r_owner;
  assign cmd_done_o  = r_cmd_done;
  assign xip_done_o  = r_xip_done;
  assign xip_break_o = (r_state == ST_BREAK);
  assign fsm_start_o = (r_state == ST_START);
  assign fsm_desc_o  = r_desc;
  assign cmd_busy_o  = r_cmd_busy;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Directed self-checking bench for qspi_bus_arbiter. Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_qspi_bus_arbiter;

  localparam int DW = 160;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_req_i, xip_req_i, xip_hold_i, fsm_done_i;
  logic [DW-1:0] cmd_desc_i, xip_desc_i;
  logic          cmd_gnt_o, cmd_done_o, xip_gnt_o, xip_done_o, xip_break_o;
  logic          fsm_start_o, cmd_busy_o;
  logic [DW-1:0] fsm_desc_o;
  logic [1:0]    owner_o;
  logic [2:0]    dbg_state_o;
`ifdef QSPI_ARB_WATCHDOG_EN
  logic          wdog_err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int hold_starts;
  bit hold_gnt_drop;

  always #5 clk = ~clk;

`ifdef QSPI_ARB_WATCHDOG_EN
  qspi_bus_arbiter #(
    .DESC_W     (DW),
    .WDOG_CYCLES(100)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_req_i  (cmd_req_i),
    .cmd_desc_i (cmd_desc_i),
    .cmd_gnt_o  (cmd_gnt_o),
    .cmd_done_o (cmd_done_o),
    .xip_req_i  (xip_req_i),
    .xip_desc_i (xip_desc_i),
    .xip_hold_i (xip_hold_i),
    .xip_gnt_o  (xip_gnt_o),
    .xip_done_o (xip_done_o),
    .xip_break_o(xip_break_o),
    .fsm_start_o(fsm_start_o),
    .fsm_desc_o (fsm_desc_o),
    .fsm_done_i (fsm_done_i),
    .cmd_busy_o (cmd_busy_o),
    .owner_o    (owner_o),
    .wdog_err_o (wdog_err_o),
    .dbg_state_o(dbg_state_o)
  );
`else
  qspi_bus_arbiter #(
    .DESC_W(DW)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_req_i  (cmd_req_i),
    .cmd_desc_i (cmd_desc_i),
    .cmd_gnt_o  (cmd_gnt_o),
    .cmd_done_o (cmd_done_o),
    .xip_req_i  (xip_req_i),
    .xip_desc_i (xip_desc_i),
    .xip_hold_i (xip_hold_i),
    .xip_gnt_o  (xip_gnt_o),
    .xip_done_o (xip_done_o),
    .xip_break_o(xip_break_o),
    .fsm_start_o(fsm_start_o),
    .fsm_desc_o (fsm_desc_o),
    .fsm_done_i (fsm_done_i),
    .cmd_busy_o (cmd_busy_o),
    .owner_o    (owner_o),
    .dbg_state_o(dbg_state_o)
  );
`endif

  function automatic logic [DW-1:0] mk_desc(input int k);
    logic [31:0] w;
    w = 32'hA5C3_0000 + 32'(k);
    return {w, ~w, w ^ 32'h0F0F_0F0F, w, 32'(k * 7)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic tick_hold();
    @(negedge clk);
    hold_starts += int'(fsm_start_o);
    if (!xip_gnt_o) hold_gnt_drop = 1'b1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fsm_start_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [11:0] v;
    resetn = 1'b0; cmd_req_i = 0; xip_req_i = 0; xip_hold_i = 0; fsm_done_i = 0;
    cmd_desc_i = '0; xip_desc_i = '0;
    tick(); tick();
    v = {cmd_gnt_o, cmd_done_o, xip_gnt_o, xip_done_o, xip_break_o, fsm_start_o,
         cmd_busy_o, owner_o, dbg_state_o};
    n_checks++;
    if (v !== 12'h000) begin n_fail++; $display("FAIL reset_outputs got=%h exp=000", v); end
    n_checks++;
    if (fsm_desc_o !== '0) begin n_fail++; $display("FAIL reset_desc got=%h exp=0", fsm_desc_o); end
    resetn = 1'b1;
    tick();
    fsm_done_i = 1'b1;
    tick();
    fsm_done_i = 1'b0;
    v = {5'b0, cmd_done_o, xip_done_o, owner_o, dbg_state_o};
    n_checks++;
    if (v !== 12'h000) begin n_fail++; $display("FAIL idle_done_ignored got=%h exp=000", v); end
  endtask

  task automatic test_cmd_b2b();
    logic [4:0] v;
    cmd_desc_i = mk_desc(1);
    cmd_req_i  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      v = {fsm_start_o, cmd_gnt_o, xip_gnt_o, owner_o};
      n_checks++;
      if (v !== 5'b1_1_0_01) begin n_fail++; $display("FAIL b2b_start%0d got=%b exp=11001", k, v); end
      n_checks++;
      if (fsm_desc_o !== mk_desc(k)) begin
        n_fail++; $display("FAIL b2b_desc%0d got=%h exp=%h", k, fsm_desc_o, mk_desc(k));
      end
      tick();
      v = {fsm_start_o, owner_o, dbg_state_o[1:0]};
      n_checks++;
      if (v !== 5'b0_01_10) begin n_fail++; $display("FAIL b2b_busy%0d got=%b exp=00110", k, v); end
      n_checks++;
      if (cmd_busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_cmd_busy%0d got=%b exp=1", k, cmd_busy_o); end
      fsm_done_i = 1'b1;
      tick();
      fsm_done_i = 1'b0;
      v = {cmd_done_o, xip_done_o, cmd_gnt_o, owner_o};
      n_checks++;
      if (v !== 5'b1_0_0_00) begin n_fail++; $display("FAIL b2b_done%0d got=%b exp=10000", k, v); end
      if (k < 3) cmd_desc_i = mk_desc(k + 1);
      else       cmd_req_i  = 1'b0;
    end
    tick();
    v = {cmd_done_o, owner_o, dbg_state_o[1:0]};
    n_checks++;
    if (v !== 5'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=00000", v); end
  endtask

  task automatic test_streak();
    logic [1:0] exp_q[$];
    logic [1:0] e;
    logic [1:0] d;
    bit ok;
    exp_q = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    cmd_desc_i = mk_desc(20); xip_desc_i = mk_desc(21);
    xip_hold_i = 1'b0; cmd_req_i = 1'b1; xip_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      wait_start(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL streak_timeout%0d got=no_start exp=start", i); end
      n_checks++;
      if (owner_o !== e) begin n_fail++; $display("FAIL streak_owner%0d got=%b exp=%b", i, owner_o, e); end
      tick();
      fsm_done_i = 1'b1;
      tick();
      fsm_done_i = 1'b0;
      if (i == 9) begin cmd_req_i = 1'b0; xip_req_i = 1'b0; end
      d = {cmd_done_o, xip_done_o};
      n_checks++;
      if (d !== ((e == 2'b01) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL streak_done%0d got=%b exp_owner=%b", i, d, e);
      end
    end
    tick();
  endtask

  task automatic test_hold_reads();
    hold_starts = 0; hold_gnt_drop = 1'b0;
    xip_hold_i = 1'b1;
    for (int r = 0; r < 8; r++) begin
      xip_desc_i = mk_desc(30 + r);
      xip_req_i  = 1'b1;
      tick_hold();
      tick_hold();
      fsm_done_i = 1'b1;
      tick_hold();
      fsm_done_i = 1'b0;
      xip_req_i  = 1'b0;
      n_checks++;
      if ({xip_done_o, dbg_state_o} !== 4'b1_011) begin
        n_fail++; $display("FAIL hold_read%0d got=%b exp=1011", r, {xip_done_o, dbg_state_o});
      end
      tick_hold();
      tick_hold();
    end
    n_checks++;
    if (hold_starts !== 8) begin n_fail++; $display("FAIL hold_starts got=%0d exp=8", hold_starts); end
    n_checks++;
    if (hold_gnt_drop !== 1'b0) begin n_fail++; $display("FAIL hold_gnt_drop got=%b exp=0", hold_gnt_drop); end
    xip_hold_i = 1'b0;
    tick();
    n_checks++;
    if ({xip_gnt_o, owner_o, dbg_state_o} !== 6'b0) begin
      n_fail++; $display("FAIL hold_release got=%b exp=000000", {xip_gnt_o, owner_o, dbg_state_o});
    end
  endtask

  task automatic test_break();
    bit busy_ok;
    xip_hold_i = 1'b1; xip_desc_i = mk_desc(40); xip_req_i = 1'b1;
    tick(); tick();
    fsm_done_i = 1'b1;
    tick();
    fsm_done_i = 1'b0; xip_req_i = 1'b0;
    tick();
    cmd_desc_i = mk_desc(50); cmd_req_i = 1'b1;
    tick();
    n_checks++;
    if ({xip_break_o, dbg_state_o} !== 4'b1_100) begin
      n_fail++; $display("FAIL break_assert got=%b exp=1100", {xip_break_o, dbg_state_o});
    end
    busy_ok = cmd_busy_o;
    xip_desc_i = mk_desc(41); xip_req_i = 1'b1;
    tick();
    busy_ok &= cmd_busy_o;
    n_checks++;
    if ({fsm_start_o, owner_o, xip_break_o} !== 4'b1_10_0) begin
      n_fail++; $display("FAIL break_term_start got=%b exp=1100", {fsm_start_o, owner_o, xip_break_o});
    end
    n_checks++;
    if (fsm_desc_o !== mk_desc(41)) begin
      n_fail++; $display("FAIL break_term_desc got=%h exp=%h", fsm_desc_o, mk_desc(41));
    end
    tick();
    busy_ok &= cmd_busy_o;
    fsm_done_i = 1'b1;
    tick();
    fsm_done_i = 1'b0; xip_req_i = 1'b0;
    busy_ok &= cmd_busy_o;
    n_checks++;
    if ({xip_done_o, owner_o, dbg_state_o} !== 6'b1_00_000) begin
      n_fail++; $display("FAIL break_term_idle got=%b exp=100000", {xip_done_o, owner_o, dbg_state_o});
    end
    tick();
    busy_ok &= cmd_busy_o;
    n_checks++;
    if ({fsm_start_o, cmd_gnt_o, owner_o} !== 4'b1_1_01) begin
      n_fail++; $display("FAIL break_cmd_grant got=%b exp=1101", {fsm_start_o, cmd_gnt_o, owner_o});
    end
    n_checks++;
    if (fsm_desc_o !== mk_desc(50)) begin
      n_fail++; $display("FAIL break_cmd_desc got=%h exp=%h", fsm_desc_o, mk_desc(50));
    end
    tick();
    busy_ok &= cmd_busy_o;
    fsm_done_i = 1'b1;
    tick();
    fsm_done_i = 1'b0; cmd_req_i = 1'b0; xip_hold_i = 1'b0;
    n_checks++;
    if (cmd_done_o !== 1'b1) begin n_fail++; $display("FAIL break_cmd_done got=%b exp=1", cmd_done_o); end
    n_checks++;
    if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL break_cmd_busy got=%b exp=1", busy_ok); end
    tick();
  endtask

  task automatic test_hold_timeout();
    int n;
    xip_hold_i = 1'b1; xip_desc_i = mk_desc(70); xip_req_i = 1'b1;
    tick(); tick();
    fsm_done_i = 1'b1;
    tick();
    fsm_done_i = 1'b0; xip_req_i = 1'b0;
    n = 0;
    while (n < 100 && !xip_break_o) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 64) begin n_fail++; $display("FAIL hold_timeout_cycles got=%0d exp=64", n); end
    n_checks++;
    if (dbg_state_o !== 3'd4) begin n_fail++; $display("FAIL hold_timeout_state got=%0d exp=4", dbg_state_o); end
    xip_hold_i = 1'b0;
    tick();
    n_checks++;
    if ({xip_break_o, owner_o, dbg_state_o} !== 6'b0) begin
      n_fail++; $display("FAIL break_hold_drop got=%b exp=000000", {xip_break_o, owner_o, dbg_state_o});
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [11:0] v;
    cmd_desc_i = mk_desc(60); cmd_req_i = 1'b1;
    tick(); tick();
    #2 resetn = 1'b0;
    #1;
    v = {cmd_gnt_o, cmd_done_o, xip_gnt_o, xip_done_o, xip_break_o, fsm_start_o,
         cmd_busy_o, owner_o, dbg_state_o};
    n_checks++;
    if (v !== 12'h000) begin n_fail++; $display("FAIL async_reset_outputs got=%h exp=000", v); end
    n_checks++;
    if (fsm_desc_o !== '0) begin n_fail++; $display("FAIL async_reset_desc got=%h exp=0", fsm_desc_o); end
    cmd_req_i = 1'b0;
    tick();
    resetn = 1'b1; cmd_desc_i = mk_desc(61); cmd_req_i = 1'b1;
    tick();
    n_checks++;
    if ({fsm_start_o, cmd_gnt_o, owner_o} !== 4'b1_1_01) begin
      n_fail++; $display("FAIL post_reset_grant got=%b exp=1101", {fsm_start_o, cmd_gnt_o, owner_o});
    end
    n_checks++;
    if (fsm_desc_o !== mk_desc(61)) begin
      n_fail++; $display("FAIL post_reset_desc got=%h exp=%h", fsm_desc_o, mk_desc(61));
    end
    tick();
    fsm_done_i = 1'b1;
    tick();
    fsm_done_i = 1'b0; cmd_req_i = 1'b0;
    n_checks++;
    if (cmd_done_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_done got=%b exp=1", cmd_done_o); end
    tick();
  endtask

`ifdef QSPI_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    cmd_desc_i = mk_desc(80); cmd_req_i = 1'b1;
    tick(); tick();
    n = 0;
    while (n < 200 && !wdog_err_o) begin
      tick();
      n++;
    end
    cmd_req_i = 1'b0;
    n_checks++;
    if (n !== 100) begin n_fail++; $display("FAIL wdog_cycles got=%0d exp=100", n); end
    n_checks++;
    if ({cmd_done_o, owner_o} !== 3'b1_00) begin
      n_fail++; $display("FAIL wdog_done got=%b exp=100", {cmd_done_o, owner_o});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_cmd_b2b();
    test_streak();
    test_hold_reads();
    test_break();
    test_hold_timeout();
    test_reset_mid_busy();
`ifdef QSPI_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
